or1200_mult_mac_pipe: RTL and testbench
=======================================

Name: or1200_mult_mac_pipe

Overview:
- Parametrised, pipelined WIDTHxWIDTH multiplier with an optional multiply-accumulate datapath.
- Next generation of the single-stage 32x32 multiplier in the OR1200 ALU/MAC path. Adds selectable signedness, STAGES-deep pipelining and a valid/ready handshake with back-pressure.
- Adds a 2*WIDTH accumulator supporting MAC/MSB operations with sticky overflow. Sits between the OR1200 operand muxes and the MAC/SPR writeback.

Parameters:
- WIDTH, 32, operand width; product and accumulator are 2*WIDTH. Legal values 8..64.
- STAGES, 3, pipeline depth = input-to-output latency in cycles. Legal values 1..4.
- MAC_EN, 1, 1 = accumulator logic present; 0 = MAC/MSB ops behave as signed MUL and acc_o is tied to 0.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous pipeline flush: clears all stage valids; accumulator is kept.
- in_valid_i  in  1  operands and op are valid.
- in_ready_o  out  1  block accepts the operation this cycle.
- op_i  in  2  00 MULU, 01 MULS, 10 MAC (signed, acc += p), 11 MSB (signed, acc -= p).
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- acc_clr_i  in  1  clear accumulator and overflow flag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer takes the result.
- p_o  out  2*WIDTH  result: product for MULU/MULS, updated accumulator value for MAC/MSB.
- acc_o  out  2*WIDTH  current accumulator value.
- ovf_o  out  1  sticky signed overflow of the accumulator.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids = 0, out_valid_o = 0, p_o = 0, acc_o = 0, ovf_o = 0. If reset is asserted mid-operation, in-flight operations are discarded with no output.
- Advance enable: adv = !out_valid_o || out_ready_i. The whole pipeline moves when adv is 1 and holds all registers when adv is 0. in_ready_o = adv (combinational from out_ready_i and out_valid_o).
- Transfer: an input transfer occurs when in_valid_i && in_ready_o. An output transfer occurs when out_valid_o && out_ready_i.
- Latency: exactly STAGES cycles from input transfer to out_valid_o when there is no back-pressure. Throughput is 1 operation per cycle. Bubbles propagate as valid = 0.
- Arithmetic:
  - MULU: both operands zero-extended to 2*WIDTH.
  - MULS/MAC/MSB: both operands sign-extended.
  - Product is the low 2*WIDTH bits of the extended multiply.
- Pipeline structure: stage 1 registers the extended operands and op. The partial-product split across stages is free, provided results are bit-exact at the stated latency.
- Accumulator:
  - Updated only in the cycle the final-stage MAC/MSB result is loaded into the output register (adv = 1, final valid).
  - base = acc_clr_i ? 0 : acc. acc_next = base + p for MAC, base - p for MSB. Wraps modulo 2^(2W).
  - p_o = acc_next for MAC/MSB.
  - ovf set when the signed add/sub overflows. ovf is sticky until acc_clr_i or reset.
- acc_clr_i without a MAC/MSB in the final stage: acc = 0, ovf = 0 at the next edge, regardless of adv.
- Simultaneous acc_clr_i and a MAC/MSB in the final stage: clear first, then apply the operation (acc = ±p). ovf is recomputed from the result against base 0, so it can only set for MSB of the most negative product.
- MUL ops never touch acc or ovf.
- Ordering: back-to-back MACs accumulate in issue order, with no hazard stall needed because only the final stage uses acc.
- Flush:
  - flush_i clears every stage valid and out_valid_o at the next edge. An input transfer in the same cycle is dropped.
  - A MAC in the final stage when flush_i is asserted does not update acc.
  - flush_i has priority over adv.
- STAGES = 1: a single register between inputs and outputs. The rules above still hold.

Decomposition:
- Shared package or1200_mult_pkg:
  - Op encoding constants MULU/MULS/MAC/MSB.
  - Function for operand extension by op.
  - Localparam PW = 2*WIDTH computation helper.
- Sub-module or1200_mult_pipe_stage: one valid+data register slice with adv/flush, instantiated per stage via generate. The accumulator update stays in the top level.

Test Plan:
- WIDTH=32, STAGES=3, MULU a=0xFFFFFFFF b=0xFFFFFFFF -> after 3 cycles p_o=0xFFFFFFFE00000001, out_valid_o=1 for 1 cycle; then MULS same operands -> p_o=0x0000000000000001.
- Stream MULS 1x1, 2x3, -4x5 on consecutive cycles with out_ready_i=1 -> p_o = 1, 6, 0xFFFFFFFFFFFFFFEC on three consecutive cycles starting at cycle 3.
- out_ready_i=0 while 4 operations are issued -> in_ready_o drops once out_valid_o=1. Release out_ready_i -> all 4 results arrive in order with no loss or duplication, and in_ready_o=1 again.
- acc_clr_i, then MAC 3x4, MAC 5x6, MSB 2x2 -> p_o = 12, 42, 38, acc_o=38, ovf_o=0. A MUL in between leaves acc_o unchanged.
- WIDTH=8: MAC 0x80x0x80 (+16384) issued repeatedly until acc exceeds 0x7FFF -> acc wraps and ovf_o=1, which stays 1 until acc_clr_i, then acc_o=0 and ovf_o=0.
- Assert rst_n low with 2 operations in flight -> outputs immediately 0. flush_i with a MAC in flight -> no out_valid_o and acc_o unchanged.

Source files
------------

// File: rtl/or1200_mult_pkg.sv
// Shared definitions for the OR1200 pipelined multiplier / MAC: op encoding,
// product-width helper and operand extension.
package or1200_mult_pkg;

  typedef enum logic [1:0] {
    OpMulu = 2'b00,
    OpMuls = 2'b01,
    OpMac  = 2'b10,
    OpMsb  = 2'b11
  } op_e;

  localparam int unsigned MaxWidth = 64;

  function automatic int unsigned prod_width(input int unsigned width);
    return 2 * width;
  endfunction

  // Zero-extends for MULU, sign-extends otherwise; caller slices the low 2*width bits.
  function automatic logic [2*MaxWidth-1:0] ext_operand(input logic [MaxWidth-1:0] v,
                                                        input int unsigned        width,
                                                        input op_e                op);
    logic [MaxWidth-1:0] lo;
    logic                sgn;
    lo  = v & ((64'd1 << width) - 64'd1);
    sgn = (op != OpMulu) && (|(v & (64'd1 << (width - 1))));
    return sgn ? (({(2 * MaxWidth){1'b1}} << width) | {{MaxWidth{1'b0}}, lo})
               : {{MaxWidth{1'b0}}, lo};
  endfunction

endpackage

// File: rtl/or1200_mult_mac_pipe_if.sv
// Operand/result handshake bundle of the pipelined multiplier; slave is the
// multiplier side, master the issuing/consuming side.
interface or1200_mult_mac_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned PW = 2 * WIDTH;

  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             acc_clr_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [PW-1:0]    p_o;
  logic [PW-1:0]    acc_o;
  logic             ovf_o;

  modport slave (
    input  flush_i, in_valid_i, op_i, a_i, b_i, acc_clr_i, out_ready_i,
    output in_ready_o, out_valid_o, p_o, acc_o, ovf_o
  );

  modport master (
    output flush_i, in_valid_i, op_i, a_i, b_i, acc_clr_i, out_ready_i,
    input  in_ready_o, out_valid_o, p_o, acc_o, ovf_o
  );

endinterface

// File: rtl/or1200_mult_pipe_stage.sv
// One valid+data pipeline slice: moves on adv_i, valid cleared by flush_i
// (flush wins), data only captured for valid entries.
module or1200_mult_pipe_stage #(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          adv_i,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (adv_i) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/or1200_mult_mac_pipe.sv
// Pipelined WIDTHxWIDTH multiplier with optional 2*WIDTH accumulator (MAC/MSB),
// valid/ready handshake with back-pressure and synchronous flush.
module or1200_mult_mac_pipe
  import or1200_mult_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 3,
  parameter bit          MAC_EN = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  or1200_mult_mac_pipe_if.slave bus
);

  localparam int unsigned PW = prod_width(WIDTH);
  localparam int unsigned OW = 2 + 2 * PW;

  logic          adv;
  logic          out_valid;
  logic          opd_valid [STAGES];
  logic [OW-1:0] opd_data  [STAGES];

  assign adv             = !out_valid || bus.out_ready_i;
  assign bus.in_ready_o  = adv;
  assign bus.out_valid_o = out_valid;

  // Entry 0 is the unregistered input; entries 1..STAGES-1 hold {op, a_ext, b_ext}.
  assign opd_valid[0] = bus.in_valid_i;
  assign opd_data[0]  = {bus.op_i,
                         PW'(ext_operand(MaxWidth'(bus.a_i), WIDTH, op_e'(bus.op_i))),
                         PW'(ext_operand(MaxWidth'(bus.b_i), WIDTH, op_e'(bus.op_i)))};

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    or1200_mult_pipe_stage #(
      .DW(OW)
    ) u_stage (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .adv_i  (adv),
      .flush_i(bus.flush_i),
      .valid_i(opd_valid[k-1]),
      .data_i (opd_data[k-1]),
      .valid_o(opd_valid[k]),
      .data_o (opd_data[k])
    );
  end

  op_e           fin_op;
  logic [PW-1:0] fin_a, fin_b, prod;

  assign fin_op = op_e'(opd_data[STAGES-1][OW-1 -: 2]);
  assign fin_a  = opd_data[STAGES-1][2*PW-1 -: PW];
  assign fin_b  = opd_data[STAGES-1][PW-1:0];
  // Operands are pre-extended, so the low PW bits are correct for either signedness.
  assign prod   = fin_a * fin_b;

  logic [PW-1:0] acc_q, acc_d, acc_base, acc_sum, res;
  logic          ovf_q, ovf_d, ovf_now;
  logic          is_msb, is_acc_op, acc_load;

  always_comb begin
    is_msb    = (fin_op == OpMsb);
    is_acc_op = MAC_EN && ((fin_op == OpMac) || is_msb);
    acc_load  = opd_valid[STAGES-1] && adv && !bus.flush_i && is_acc_op;
    acc_base  = bus.acc_clr_i ? '0 : acc_q;
    acc_sum   = is_msb ? (acc_base - prod) : (acc_base + prod);
    // Overflow: effective addends share a sign that the result does not.
    ovf_now   = (acc_sum[PW-1] != acc_base[PW-1]) &&
                (is_msb ? (acc_base[PW-1] != prod[PW-1]) : (acc_base[PW-1] == prod[PW-1]));
    res       = is_acc_op ? acc_sum : prod;

    acc_d = acc_q;
    ovf_d = ovf_q;
    if (acc_load) begin
      acc_d = acc_sum;
      ovf_d = (ovf_q && !bus.acc_clr_i) || ovf_now;
    end else if (bus.acc_clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  or1200_mult_pipe_stage #(
    .DW(PW)
  ) u_out (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .adv_i  (adv),
    .flush_i(bus.flush_i),
    .valid_i(opd_valid[STAGES-1]),
    .data_i (res),
    .valid_o(out_valid),
    .data_o (bus.p_o)
  );

  assign bus.acc_o = MAC_EN ? acc_q : '0;
  assign bus.ovf_o = MAC_EN ? ovf_q : 1'b0;

endmodule

// File: tb/tb_or1200_mult_mac_pipe.sv
// Scoreboard bench: a 32-bit 3-stage instance and an 8-bit 1-stage instance,
// directed vectors with hand-computed products and accumulator values.
module tb_or1200_mult_mac_pipe;
  import or1200_mult_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  or1200_mult_mac_pipe_if #(.WIDTH(32)) b32 ();
  or1200_mult_mac_pipe_if #(.WIDTH(8))  b8 ();

  or1200_mult_mac_pipe #(.WIDTH(32), .STAGES(3), .MAC_EN(1'b1)) dut32 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b32.slave)
  );

  or1200_mult_mac_pipe #(.WIDTH(8), .STAGES(1), .MAC_EN(1'b1)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b8.slave)
  );

  typedef struct {
    logic [127:0] p;
    logic [127:0] acc;
    logic         ovf;
    bit           chk_acc;
    bit           chk_lat;
    int           cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst_n && b32.out_valid_o && b32.out_ready_i) begin
      if (q32.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL out32_unexpected: got p=0x%0h expected no output", b32.p_o);
      end else begin
        e = q32.pop_front();
        chk("p32", 128'(b32.p_o), e.p);
        if (e.chk_acc) begin
          chk("acc32", 128'(b32.acc_o), e.acc);
          chk("ovf32", 128'(b32.ovf_o), 128'(e.ovf));
        end
        if (e.chk_lat) chk("lat32", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && b8.out_valid_o && b8.out_ready_i) begin
      if (q8.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL out8_unexpected: got p=0x%0h expected no output", b8.p_o);
      end else begin
        e = q8.pop_front();
        chk("p8", 128'(b8.p_o), e.p);
        if (e.chk_acc) begin
          chk("acc8", 128'(b8.acc_o), e.acc);
          chk("ovf8", 128'(b8.ovf_o), 128'(e.ovf));
        end
        if (e.chk_lat) chk("lat8", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge of the transfer.
  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] p, input bit lat, input bit chka,
                         input logic [63:0] acc, input logic ovf, input bit push);
    exp_t e;
    int   n;
    b32.in_valid_i = 1'b1;
    b32.op_i = op;
    b32.a_i = a;
    b32.b_i = b;
    @(negedge clk);
    n = 0;
    while (!b32.in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready32_wait", 128'(b32.in_ready_o), 128'(1));
    if (b32.in_ready_o && push) begin
      e.p = 128'(p);
      e.acc = 128'(acc);
      e.ovf = ovf;
      e.chk_acc = chka;
      e.chk_lat = lat;
      e.cyc = cyc + 3;
      q32.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] p, input bit chka, input logic [15:0] acc,
                        input logic ovf);
    exp_t e;
    int   n;
    b8.in_valid_i = 1'b1;
    b8.op_i = op;
    b8.a_i = a;
    b8.b_i = b;
    @(negedge clk);
    n = 0;
    while (!b8.in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready8_wait", 128'(b8.in_ready_o), 128'(1));
    if (b8.in_ready_o) begin
      e.p = 128'(p);
      e.acc = 128'(acc);
      e.ovf = ovf;
      e.chk_acc = chka;
      e.chk_lat = 1'b1;
      e.cyc = cyc + 1;
      q8.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    b32.flush_i = 0; b32.in_valid_i = 0; b32.op_i = 0; b32.a_i = 0; b32.b_i = 0;
    b32.acc_clr_i = 0; b32.out_ready_i = 1;
    b8.flush_i = 0; b8.in_valid_i = 0; b8.op_i = 0; b8.a_i = 0; b8.b_i = 0;
    b8.acc_clr_i = 0; b8.out_ready_i = 1;

    rst_n = 1'b0;
    wait_cyc(3);
    chk("rst_out_valid", 128'(b32.out_valid_o), 128'(0));
    chk("rst_p", 128'(b32.p_o), 128'(0));
    chk("rst_acc", 128'(b32.acc_o), 128'(0));
    chk("rst_ovf", 128'(b32.ovf_o), 128'(0));
    chk("rst_in_ready", 128'(b32.in_ready_o), 128'(1));
    rst_n = 1'b1;
    wait_cyc(1);

    // Extremes: unsigned vs signed interpretation of all-ones.
    issue32(OpMulu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1, 0, 0, 0, 1);
    b32.in_valid_i = 0;
    wait_cyc(4);
    issue32(OpMuls, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1, 1, 0, 0, 0, 1);
    b32.in_valid_i = 0;
    wait_cyc(4);

    // Back-to-back signed stream.
    issue32(OpMuls, 32'd1, 32'd1, 64'd1, 1, 0, 0, 0, 1);
    issue32(OpMuls, 32'd2, 32'd3, 64'd6, 1, 0, 0, 0, 1);
    issue32(OpMuls, 32'hFFFF_FFFC, 32'd5, 64'hFFFF_FFFF_FFFF_FFEC, 1, 0, 0, 0, 1);
    b32.in_valid_i = 0;
    wait_cyc(5);

    // Back-pressure: four ops issued against a stalled consumer.
    b32.out_ready_i = 1'b0;
    fork
      begin
        issue32(OpMulu, 32'd7, 32'd8, 64'd56, 0, 0, 0, 0, 1);
        issue32(OpMuls, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 1);
        issue32(OpMulu, 32'hFFFF_FFFF, 32'd2, 64'h1_FFFF_FFFE, 0, 0, 0, 0, 1);
        issue32(OpMuls, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0, 0, 0, 1);
        b32.in_valid_i = 0;
      end
      begin
        wait_cyc(8);
        chk("stall_out_valid", 128'(b32.out_valid_o), 128'(1));
        chk("stall_in_ready", 128'(b32.in_ready_o), 128'(0));
        b32.out_ready_i = 1'b1;
      end
    join
    wait_cyc(6);
    chk("drain_in_ready", 128'(b32.in_ready_o), 128'(1));
    chk("drain_out_valid", 128'(b32.out_valid_o), 128'(0));

    // Accumulate sequence with a MUL in the middle; clear both instances.
    b32.acc_clr_i = 1'b1;
    b8.acc_clr_i = 1'b1;
    wait_cyc(1);
    b32.acc_clr_i = 1'b0;
    b8.acc_clr_i = 1'b0;
    issue32(OpMac, 32'd3, 32'd4, 64'd12, 1, 1, 64'd12, 0, 1);
    issue32(OpMac, 32'd5, 32'd6, 64'd42, 1, 1, 64'd42, 0, 1);
    issue32(OpMulu, 32'd100, 32'd3, 64'd300, 1, 1, 64'd42, 0, 1);
    issue32(OpMsb, 32'd2, 32'd2, 64'd38, 1, 1, 64'd38, 0, 1);
    b32.in_valid_i = 0;
    wait_cyc(5);
    chk("mac_acc_final", 128'(b32.acc_o), 128'(38));
    chk("mac_ovf_final", 128'(b32.ovf_o), 128'(0));

    // 8-bit, single stage: wrap, sticky overflow, clear-with-op, subtract overflow.
    issue8(OpMulu, 8'hFF, 8'hFF, 16'hFE01, 1, 16'h0000, 0);
    issue8(OpMac, 8'h80, 8'h80, 16'h4000, 1, 16'h4000, 0);
    issue8(OpMac, 8'h80, 8'h80, 16'h8000, 1, 16'h8000, 1);
    issue8(OpMac, 8'h80, 8'h80, 16'hC000, 1, 16'hC000, 1);
    issue8(OpMuls, 8'h80, 8'h01, 16'hFF80, 1, 16'hC000, 1);
    b8.acc_clr_i = 1'b1;
    issue8(OpMsb, 8'h7F, 8'h80, 16'h3F80, 1, 16'h3F80, 0);
    b8.acc_clr_i = 1'b0;
    issue8(OpMsb, 8'h7F, 8'h80, 16'h7F00, 1, 16'h7F00, 0);
    issue8(OpMsb, 8'h7F, 8'h80, 16'hBE80, 1, 16'hBE80, 1);
    b8.in_valid_i = 0;
    wait_cyc(3);
    chk("ovf8_sticky", 128'(b8.ovf_o), 128'(1));
    b8.acc_clr_i = 1'b1;
    wait_cyc(1);
    b8.acc_clr_i = 1'b0;
    chk("clr8_acc", 128'(b8.acc_o), 128'(0));
    chk("clr8_ovf", 128'(b8.ovf_o), 128'(0));

    // Asynchronous reset with two operations in flight.
    issue32(OpMulu, 32'd2, 32'd2, 64'd4, 0, 0, 0, 0, 0);
    issue32(OpMulu, 32'd3, 32'd3, 64'd9, 0, 0, 0, 0, 0);
    b32.in_valid_i = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(b32.out_valid_o), 128'(0));
    chk("arst_p", 128'(b32.p_o), 128'(0));
    chk("arst_acc", 128'(b32.acc_o), 128'(0));
    chk("arst_p8", 128'(b8.p_o), 128'(0));
    q32.delete();
    q8.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cyc(5);
    chk("arst_no_output", 128'(b32.out_valid_o), 128'(0));

    // Flush: MAC dropped in the final stage, and an input dropped on the flush cycle.
    issue32(OpMac, 32'd3, 32'd4, 64'd12, 1, 1, 64'd12, 0, 1);
    b32.in_valid_i = 0;
    wait_cyc(5);
    issue32(OpMac, 32'd5, 32'd5, 64'd0, 0, 0, 0, 0, 0);
    b32.in_valid_i = 0;
    wait_cyc(1);
    b32.flush_i = 1'b1;
    wait_cyc(1);
    b32.flush_i = 1'b0;
    wait_cyc(4);
    chk("flush_acc", 128'(b32.acc_o), 128'(12));
    b32.flush_i = 1'b1;
    issue32(OpMac, 32'd7, 32'd7, 64'd0, 0, 0, 0, 0, 0);
    b32.flush_i = 1'b0;
    b32.in_valid_i = 0;
    wait_cyc(6);
    chk("flush_in_acc", 128'(b32.acc_o), 128'(12));
    chk("flush_out_valid", 128'(b32.out_valid_o), 128'(0));

    chk("q32_drained", 128'(q32.size()), 128'(0));
    chk("q8_drained", 128'(q8.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
